// File: rtl/conv_window_buffer_pkg.sv
// conv_window_buffer_pkg: shared slice macros and width helper for conv_window_buffer
`ifndef CONV_WINDOW_BUFFER_PKG_SV
`define CONV_WINDOW_BUFFER_PKG_SV
`define CWB_L(i, w) ((w)*((i)+1)-1)
`define CWB_R(i, w) ((w)*(i))
package conv_window_buffer_pkg;
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage
`endif

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: fixed-depth D_WIDTH shift register advancing only when en is high
module conv_line_buffer #(
   parameter int D_WIDTH = 8,
   parameter int DEPTH   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [D_WIDTH-1:0] in_data,
   output logic [D_WIDTH-1:0] out_data
);
   if (DEPTH == 0) begin : g_wire
      assign out_data = in_data;
   end else begin : g_sr
      logic [D_WIDTH-1:0] sr [DEPTH];
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
         end else if (en) begin
            sr[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
         end
      assign out_data = sr[DEPTH-1];
   end
endmodule

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: raster-order KERNEL x KERNEL sliding-window generator, valid-only, stride 1.
// Define CONV_WINDOW_SOF_EN to add an in_sof port that forces the accepted pixel to position (0,0).
module conv_window_buffer
   import conv_window_buffer_pkg::*;
#(
   parameter int D_WIDTH    = 8,
   parameter int KERNEL     = 3,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [D_WIDTH-1:0]                 in_data,
`ifdef CONV_WINDOW_SOF_EN
   input  logic                               in_sof,
`endif
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [D_WIDTH*KERNEL*KERNEL-1:0]   out_window,
   output logic                               out_last
);
   localparam int N  = KERNEL * KERNEL;
   localparam int CW = clog2(IMG_WIDTH);
   localparam int RW = clog2(IMG_HEIGHT);
   logic [D_WIDTH*N-1:0] win, win_next;
   logic [D_WIDTH-1:0] row_in [KERNEL];
   logic [CW-1:0] col, pos_col;
   logic [RW-1:0] row, pos_row;
   logic accept, row_end, frame_end, complete;
   assign in_ready = out_ready || !out_valid;
   assign accept = in_valid && in_ready;
`ifdef CONV_WINDOW_SOF_EN
   assign pos_col = in_sof ? '0 : col;
   assign pos_row = in_sof ? '0 : row;
`else
   assign pos_col = col;
   assign pos_row = row;
`endif
   assign row_end = pos_col == CW'(IMG_WIDTH - 1);
   assign frame_end = row_end && pos_row == RW'(IMG_HEIGHT - 1);
   assign complete = pos_row >= RW'(KERNEL - 1) && pos_col >= CW'(KERNEL - 1);
   assign row_in[KERNEL-1] = in_data;
   genvar r, c;
   // Each window row's left-most pixel, delayed by the line buffer, re-enters one row up
   for (r = 0; r < KERNEL - 1; r++) begin : g_lb
      conv_line_buffer #(.D_WIDTH(D_WIDTH), .DEPTH(IMG_WIDTH - KERNEL)) u_lb (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (accept),
         .in_data  (win[`CWB_L((r+1)*KERNEL, D_WIDTH):`CWB_R((r+1)*KERNEL, D_WIDTH)]),
         .out_data (row_in[r])
      );
   end
   for (r = 0; r < KERNEL; r++) begin : g_row
      for (c = 0; c < KERNEL; c++) begin : g_col
         if (c == KERNEL - 1) begin : g_edge
            assign win_next[`CWB_L(r*KERNEL+c, D_WIDTH):`CWB_R(r*KERNEL+c, D_WIDTH)] = row_in[r];
         end else begin : g_shift
            assign win_next[`CWB_L(r*KERNEL+c, D_WIDTH):`CWB_R(r*KERNEL+c, D_WIDTH)] =
               win[`CWB_L(r*KERNEL+c+1, D_WIDTH):`CWB_R(r*KERNEL+c+1, D_WIDTH)];
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         win       <= '0;
         col       <= '0;
         row       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept) begin
         win       <= win_next;
         col       <= row_end ? '0 : pos_col + 1'b1;
         row       <= frame_end ? '0 : row_end ? pos_row + 1'b1 : pos_row;
         out_valid <= complete;
         out_last  <= complete && frame_end;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   // The window registers only move on accept, so they double as the held output
   assign out_window = win;
endmodule
